// File: rtl/rr_arb4_enc.sv
// rr_arb4_enc: 4-requester round-robin arbiter with an encoded grant index and a
// hold-limit timer. Every grant is followed by at least one idle cycle, so the
// downstream 2:4 decoder never hands its one-hot enable directly between channels.
// The holder's "finished" input is named gnt_release because `release` is a
// reserved word in SystemVerilog.
module rr_arb4_enc #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       gnt_release,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned NREQ = 4;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic [1:0]       idx_nxt;
  logic             valid_nxt;
  logic             timeout_nxt;

  logic [1:0]       winner;
  logic [1:0]       scan_idx;
  logic             found;

  // Round-robin scan: first requester at or after ptr, wrapping modulo 4.
  always_comb begin
    winner   = ptr;
    scan_idx = ptr;
    found    = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan_idx = 2'(ptr + 2'(i));
      if (!found && req[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    idx_nxt     = gnt_idx;
    valid_nxt   = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          idx_nxt   = winner;
          valid_nxt = 1'b1;
          hold_nxt  = '0;
        end
      end
      GRANT: begin
        if (gnt_release || !req[gnt_idx]) begin
          // Normal exit; takes precedence over a simultaneous hold limit.
          state_nxt = IDLE;
          ptr_nxt   = 2'(gnt_idx + 2'd1);
          hold_nxt  = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          // Forced exit: grant held for HOLD_MAX cycles.
          state_nxt   = IDLE;
          ptr_nxt     = 2'(gnt_idx + 2'd1);
          hold_nxt    = '0;
          timeout_nxt = 1'b1;
        end else begin
          valid_nxt = 1'b1;
          hold_nxt  = CNT_W'(hold_cnt + 1'b1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      gnt_idx   <= idx_nxt;
      gnt_valid <= valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_rr_arb4_enc.sv
// Bench for rr_arb4_enc: directed stimulus pushes expected grants (index, length,
// timeout-on-exit) into a queue; a monitor reconstructs each grant from the outputs.
module tb_rr_arb4_enc;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       gnt_release;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  typedef struct {
    logic [1:0] idx;
    int         len;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  rr_arb4_enc #(.HOLD_MAX(15), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .gnt_release (gnt_release),
    .gnt_idx     (gnt_idx),
    .gnt_valid   (gnt_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input logic [1:0] idx, input int len, input logic to);
    exp_t e;
    e.idx = idx;
    e.len = len;
    e.to  = to;
    exp_q.push_back(e);
  endtask

  // Monitor: rebuild each grant from gnt_valid/gnt_idx and score it on exit.
  initial begin
    logic       prev_valid;
    logic [1:0] cur_idx;
    int         cur_len;
    exp_t       e;
    prev_valid = 1'b0;
    cur_idx    = 2'd0;
    cur_len    = 0;
    forever begin
      @(negedge clk);
      if (gnt_valid === 1'b1 && !prev_valid) begin
        cur_idx = gnt_idx;
        cur_len = 1;
      end else if (gnt_valid === 1'b1) begin
        cur_len++;
        check("idx_stable", int'(gnt_idx), int'(cur_idx));
      end else if (prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("grant_idx", int'(cur_idx), int'(e.idx));
          check("grant_len", cur_len, e.len);
          check("exit_timeout", int'(timeout === 1'b1), int'(e.to));
        end
      end else if (timeout !== 1'b0) begin
        check("spurious_timeout", int'(timeout === 1'b1), 0);
      end
      prev_valid = (gnt_valid === 1'b1);
    end
  end

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    gnt_release = 1'b0;

    // 1: reset, single grant, release
    tick(2);
    check("rst_valid", int'(gnt_valid), 0);
    check("rst_idx", int'(gnt_idx), 0);
    check("rst_timeout", int'(timeout), 0);
    rst = 1'b0;
    req = 4'b0001;
    expect_grant(2'd0, 1, 1'b0);
    tick(1);
    gnt_release = 1'b1;
    req = 4'b0000;
    tick(1);
    gnt_release = 1'b0;
    tick(1);
    check("ptr_after_rel", int'(dut.ptr), 1);

    // 2: rotation from reset, release held
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    req = 4'b1111;
    gnt_release = 1'b1;
    expect_grant(2'd0, 1, 1'b0);
    expect_grant(2'd1, 1, 1'b0);
    expect_grant(2'd2, 1, 1'b0);
    expect_grant(2'd3, 1, 1'b0);
    expect_grant(2'd0, 1, 1'b0);
    tick(10);
    req = 4'b0000;
    gnt_release = 1'b0;
    tick(1);

    // 3: hold-limit timeout then re-grant; 5: release on 15th cycle of re-grant
    req = 4'b0100;
    expect_grant(2'd2, 15, 1'b1);
    expect_grant(2'd2, 15, 1'b0);
    tick(31);
    gnt_release = 1'b1;
    tick(1);
    gnt_release = 1'b0;
    req = 4'b0000;
    tick(2);

    // 4: requester drop, then next arbitration from ptr=2
    req = 4'b0010;
    expect_grant(2'd1, 4, 1'b0);
    tick(4);
    req = 4'b0000;
    tick(1);
    req = 4'b0110;
    expect_grant(2'd2, 2, 1'b0);
    tick(2);
    gnt_release = 1'b1;
    req = 4'b0000;
    tick(1);
    gnt_release = 1'b0;
    tick(1);

    // 6: reset mid-grant of idx 3, then ptr restarts at 0
    req = 4'b1000;
    expect_grant(2'd3, 3, 1'b0);
    tick(3);
    rst = 1'b1;
    tick(1);
    check("midrst_valid", int'(gnt_valid), 0);
    check("midrst_idx", int'(gnt_idx), 0);
    check("midrst_timeout", int'(timeout), 0);
    rst = 1'b0;
    req = 4'b1010;
    expect_grant(2'd1, 2, 1'b0);
    tick(2);
    gnt_release = 1'b1;
    req = 4'b0000;
    tick(1);
    gnt_release = 1'b0;
    tick(3);

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/rr_arb4_enc.md
Name: rr_arb4_enc

Overview:
- 4-requester round-robin arbiter with a hold-limit timer.
- Produces the 2-bit encoded grant index `gnt_idx` plus a qualifier `gnt_valid`. This is the select source that feeds the 2:4 decoder stage, whose one-hot output drives per-channel enables.
- Guarantees at least one dead cycle between consecutive grants, so the downstream one-hot enable is never handed directly between channels.

Parameters:
- HOLD_MAX, 15: maximum number of consecutive cycles one grant may stay asserted. Legal range 1..(2**CNT_W).
- CNT_W, 4: width of the internal hold counter.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; bit i = channel i requests.
- release  input  1  current grant holder finished; sampled only while gnt_valid=1.
- gnt_idx  output  2  encoded index of granted channel; feeds decoder `in[1:0]`.
- gnt_valid  output  1  gnt_idx is a live grant; decoder output is qualified by this.
- timeout  output  1  single-cycle pulse: previous grant was forcibly revoked by the hold limit.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, gnt_idx=2'b00, gnt_valid=0, timeout=0, ptr=0, hold_cnt=0. Reset overrides every other condition, including mid-grant.
- Registers:
  - ptr[1:0]: highest-priority channel for the next arbitration.
  - hold_cnt[CNT_W-1:0]: cycles the current grant has been held.
- States: IDLE, GRANT. All outputs are registered.
- IDLE, req==0: stay in IDLE; outputs hold; timeout=0.
- IDLE, req!=0:
  - Winner = first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Next cycle: gnt_valid=1, gnt_idx=winner, hold_cnt=0, state=GRANT.
  - Latency from req sampled in IDLE to gnt_valid high: 1 cycle.
- GRANT, each cycle: evaluate exit conditions in priority order.
  1. release=1 -> normal exit.
  2. req[gnt_idx]=0 (requester dropped) -> normal exit.
  3. hold_cnt==HOLD_MAX-1 -> forced exit.
  4. Otherwise hold_cnt+=1; gnt_idx unchanged; remain in GRANT.
- On any exit, next cycle: gnt_valid=0, state=IDLE, ptr=(gnt_idx+1) mod 4 (2-bit wrap, 3->0), hold_cnt=0.
- timeout=1 for exactly one cycle (the first cycle with gnt_valid=0) only on a forced exit. It is 0 in all other cycles.
- Simultaneous release=1 and hold-limit reached: treated as a normal exit, so timeout stays 0.
- gnt_valid is high for at most HOLD_MAX consecutive cycles per grant. It is low for at least 1 cycle between grants, since IDLE is always visited.
- gnt_idx retains its last value while gnt_valid=0 (0 after reset). Consumers must qualify it with gnt_valid.
- req changes in non-winning bits during GRANT are ignored until the next IDLE arbitration.
- release while gnt_valid=0 is ignored.
- HOLD_MAX=1: every grant lasts exactly 1 cycle. Exit is forced unless release=1 or the requester dropped, in which case it is a normal exit.

Test Plan:
1. Basic grant/release: rst 2 cycles, then req=4'b0001. Expect gnt_valid=1, gnt_idx=0 one cycle later. Pulse release=1 for 1 cycle. Expect gnt_valid=0 next cycle, timeout=0, ptr=1.
2. Rotation: req=4'b1111 held; release=1 on every gnt_valid cycle. Expect gnt_idx sequence 0,1,2,3,0, each valid for 1 cycle, separated by exactly one gnt_valid=0 cycle.
3. Timeout: HOLD_MAX=15, req=4'b0100 held, release=0. Expect gnt_valid=1 with gnt_idx=2 for exactly 15 cycles, then 1 cycle gnt_valid=0 with timeout=1, then re-grant of idx 2 (sole requester, pointer wrapped to 3 -> scan reaches 2).
4. Requester drop: grant held on idx 1; deassert req[1] with release=0. Expect gnt_valid=0 next cycle, timeout=0, next arbitration starts at ptr=2.
5. Simultaneous events: req=4'b0100 held; assert release=1 exactly on the 15th grant cycle. Expect normal exit, timeout remains 0.
6. Reset mid-grant: during a grant of idx 3, assert rst for 1 cycle. Expect gnt_valid=0, gnt_idx=0, timeout=0 on the next edge. Then apply req=4'b1010: expect gnt_idx=1, since ptr was reset to 0.
